scratch_pad_mover: RTL and testbench

Single-port copy engine that drives one port of the banked scratch pad as a requester. It accepts a (source, destination, length) command, streams reads out of the scratch pad, buffers the in-order read returns, and writes them back to the destination region. It is the initiator end of the scratch-pad port protocol: it produces rd_en/wr_en/addr/d, honours full, and consumes q/valid while driving stall.

---
 rtl/scratch_pad_mover.sv | 148 ++++++++++++++
 tb/tb_scratch_pad_mover.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/scratch_pad_mover.sv
// Scratch-pad copy engine: streams reads from a source region into a small
// return FIFO and writes them back out to a destination region.
module scratch_pad_mover #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int BUF_DEPTH  = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_src,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  done,
  output logic                  sp_rd_en,
  output logic                  sp_wr_en,
  output logic [ADDR_WIDTH-1:0] sp_addr,
  output logic [WIDTH-1:0]      sp_d,
  input  logic                  sp_full,
  input  logic [WIDTH-1:0]      sp_q,
  input  logic                  sp_valid,
  output logic                  sp_stall
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
  logic [LEN_WIDTH-1:0]  rd_left_q, rd_left_d;
  logic [LEN_WIDTH-1:0]  wr_left_q, wr_left_d;
  logic [CNT_W-1:0]      inflight_q, inflight_d;
  logic [CNT_W-1:0]      fcount_q, fcount_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [WIDTH-1:0]      fifo_mem_q [BUF_DEPTH];

  logic             run;
  logic             wr_go;
  logic             rd_go;
  logic             push;
  logic [CNT_W:0]   credit_used;

  // Request selection: writes drain the FIFO first; reads only when a FIFO slot is reserved.
  always_comb begin
    run         = (state_q == S_RUN) && !rst;
    credit_used = {1'b0, inflight_q} + {1'b0, fcount_q};
    sp_stall    = !rst && (fcount_q == CNT_W'(BUF_DEPTH));
    wr_go       = run && !sp_full && (fcount_q != '0);
    rd_go       = run && !sp_full && !wr_go && (rd_left_q != '0) &&
                  (credit_used < (CNT_W + 1)'(BUF_DEPTH));
    push        = run && sp_valid && !sp_stall;
    sp_wr_en    = wr_go;
    sp_rd_en    = rd_go;
    sp_addr     = '0;
    sp_d        = '0;
    if (wr_go) begin
      sp_addr = dst_ptr_q;
      sp_d    = fifo_mem_q[head_q];
    end else if (rd_go) begin
      sp_addr = src_ptr_q;
    end
    cmd_ready = (state_q == S_IDLE) && !rst;
    done      = (state_q == S_DONE) && !rst;
  end

  always_comb begin
    state_d    = state_q;
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    rd_left_d  = rd_left_q;
    wr_left_d  = wr_left_q;
    inflight_d = inflight_q + CNT_W'(rd_go) - CNT_W'(push);
    fcount_d   = fcount_q + CNT_W'(push) - CNT_W'(wr_go);
    head_d     = head_q + PTR_W'(wr_go);
    tail_d     = tail_q + PTR_W'(push);
    if (rd_go) begin
      src_ptr_d = src_ptr_q + 1'b1;
      rd_left_d = rd_left_q - 1'b1;
    end
    if (wr_go) begin
      dst_ptr_d = dst_ptr_q + 1'b1;
      wr_left_d = wr_left_q - 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d   = S_RUN;
          src_ptr_d = cmd_src;
          dst_ptr_d = cmd_dst;
          rd_left_d = cmd_len;
          wr_left_d = cmd_len;
        end
      end
      // Leave RUN on the edge that retires the final write so done follows it directly.
      S_RUN: begin
        if (wr_left_d == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      src_ptr_q  <= '0;
      dst_ptr_q  <= '0;
      rd_left_q  <= '0;
      wr_left_q  <= '0;
      inflight_q <= '0;
      fcount_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      src_ptr_q  <= src_ptr_d;
      dst_ptr_q  <= dst_ptr_d;
      rd_left_q  <= rd_left_d;
      wr_left_q  <= wr_left_d;
      inflight_q <= inflight_d;
      fcount_q   <= fcount_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[tail_q] <= sp_q;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && sp_valid && (state_q != S_RUN))
      $warning("scratch_pad_mover: sp_valid outside a copy, return ignored");
  end
`endif

endmodule

// File: tb/tb_scratch_pad_mover.sv
// Directed bench for scratch_pad_mover with a behavioural scratch pad of fixed read latency.
module tb_scratch_pad_mover;
  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_src = '0;
  logic [7:0]  cmd_dst = '0;
  logic [8:0]  cmd_len = '0;
  logic        done;
  logic        sp_rd_en, sp_wr_en;
  logic [7:0]  sp_addr;
  logic [15:0] sp_d;
  logic        sp_full = 1'b0;
  logic [15:0] sp_q;
  logic        sp_valid;
  logic        sp_stall;

  always #5 clk = ~clk;

  scratch_pad_mover dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .done(done),
    .sp_rd_en(sp_rd_en), .sp_wr_en(sp_wr_en), .sp_addr(sp_addr), .sp_d(sp_d),
    .sp_full(sp_full), .sp_q(sp_q), .sp_valid(sp_valid), .sp_stall(sp_stall)
  );

  // Scratch pad model with L-cycle read latency and a preload port.
  logic [15:0] mem [256];
  logic [L-1:0] rv;
  logic [15:0] rq [L];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  always @(posedge clk) begin
    if (rst) rv <= '0;
    else     rv <= {rv[L-2:0], sp_rd_en};
    rq[0] <= mem[sp_addr];
    for (int i = 1; i < L; i++) rq[i] <= rq[i-1];
    if (sp_wr_en) mem[sp_addr] <= sp_d;
    if (pl_en) mem[pl_addr] <= pl_data;
  end
  assign sp_valid = rv[L-1];
  assign sp_q     = rq[L-1];

  // Protocol monitor.
  int rd_cnt, wr_cnt, done_cnt, out_cnt;
  int viol_both, viol_full, viol_stall, viol_idle, viol_addr, viol_credit;
  logic [7:0] exp_rd, exp_wr, last_rd, last_wr;

  always @(negedge clk) begin
    if (rst) begin
      out_cnt = 0;
    end else begin
      if (sp_rd_en && sp_wr_en) viol_both++;
      if ((sp_rd_en || sp_wr_en) && sp_full) viol_full++;
      if (sp_stall) viol_stall++;
      if (!sp_rd_en && !sp_wr_en && sp_addr != 8'h00) viol_idle++;
      if (!sp_wr_en && sp_d != 16'h0000) viol_idle++;
      if (sp_rd_en) begin
        if (sp_addr !== exp_rd) viol_addr++;
        last_rd = sp_addr;
        exp_rd  = exp_rd + 8'd1;
        rd_cnt++;
        out_cnt++;
      end
      if (sp_wr_en) begin
        if (sp_addr !== exp_wr) viol_addr++;
        last_wr = sp_addr;
        exp_wr  = exp_wr + 8'd1;
        wr_cnt++;
        out_cnt--;
      end
      if (out_cnt > 8) viol_credit++;
      if (done) done_cnt++;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic preload(input logic [7:0] addr, input logic [15:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      pl_en   = 1'b1;
      pl_addr = 8'(addr + i);
      pl_data = 16'(base + i);
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
  endtask

  task automatic start_cmd(input logic [7:0] src, input logic [7:0] dst, input logic [8:0] len);
    check("cmd_ready_before_cmd", cmd_ready, 1);
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    viol_both = 0; viol_full = 0; viol_stall = 0; viol_idle = 0; viol_addr = 0; viol_credit = 0;
    exp_rd = src; exp_wr = dst; last_rd = 8'h00; last_wr = 8'h00;
    cmd_src = src; cmd_dst = dst; cmd_len = len;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", (n >= 2000) ? 1 : 0, 0);
    @(posedge clk); #1;
    check("ready_after_done", cmd_ready, 1);
  endtask

  task automatic check_copy(input logic [7:0] dst, input logic [15:0] base, input int len);
    int errs = 0;
    for (int i = 0; i < len; i++)
      if (mem[8'(dst + i)] !== 16'(base + i)) errs++;
    check("copy_data", errs, 0);
  endtask

  function automatic int proto_viol();
    return viol_both + viol_full + viol_stall + viol_idle + viol_addr + viol_credit;
  endfunction

  typedef struct {
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [8:0]  len;
    logic [15:0] base;
    logic [7:0]  last_rd;
    logic [7:0]  last_wr;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{src: 8'h10, dst: 8'h40, len: 9'd4,  base: 16'h00A0, last_rd: 8'h13, last_wr: 8'h43};
    vecs[1] = '{src: 8'hFE, dst: 8'h02, len: 9'd4,  base: 16'h1230, last_rd: 8'h01, last_wr: 8'h05};
    vecs[2] = '{src: 8'h20, dst: 8'h50, len: 9'd13, base: 16'h5550, last_rd: 8'h2C, last_wr: 8'h5C};
    vecs[3] = '{src: 8'h30, dst: 8'h70, len: 9'd1,  base: 16'hBEEF, last_rd: 8'h30, last_wr: 8'h70};

    // Reset held with a command offered: nothing visible, nothing taken.
    cmd_valid = 1'b1; cmd_src = 8'h55; cmd_dst = 8'h66; cmd_len = 9'd5;
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_outputs", {cmd_ready, done, sp_rd_en, sp_wr_en, sp_addr, sp_d, sp_stall}, 0);
    end
    rst = 1'b0; cmd_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("no_cmd_taken", {cmd_ready, done, sp_rd_en, sp_wr_en}, 4'b1000);
    end

    for (int v = 0; v < 4; v++) begin
      preload(vecs[v].src, vecs[v].base, int'(vecs[v].len));
      start_cmd(vecs[v].src, vecs[v].dst, vecs[v].len);
      wait_done();
      check("rd_count", rd_cnt, vecs[v].len);
      check("wr_count", wr_cnt, vecs[v].len);
      check("done_pulses", done_cnt, 1);
      check("last_rd_addr", last_rd, vecs[v].last_rd);
      check("last_wr_addr", last_wr, vecs[v].last_wr);
      check("protocol", proto_viol(), 0);
      check_copy(vecs[v].dst, vecs[v].base, int'(vecs[v].len));
    end

    // Back-pressure: full held for 20 cycles mid-copy.
    preload(8'h80, 16'h7000, 32);
    start_cmd(8'h80, 8'hC0, 9'd32);
    repeat (10) begin @(posedge clk); #1; end
    sp_full = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    sp_full = 1'b0;
    wait_done();
    check("bp_rd_count", rd_cnt, 32);
    check("bp_wr_count", wr_cnt, 32);
    check("bp_req_while_full", viol_full, 0);
    check("bp_credit", viol_credit, 0);
    check("bp_stall", viol_stall, 0);
    check("bp_done_pulses", done_cnt, 1);
    check("bp_protocol", proto_viol(), 0);
    check_copy(8'hC0, 16'h7000, 32);

    // Zero length, then a command accepted immediately in cycle 3.
    preload(8'hA8, 16'h0C00, 2);
    start_cmd(8'h33, 8'h44, 9'd0);
    check("zero_len_cycle1_done", done, 0);
    @(posedge clk); #1;
    check("zero_len_cycle2_done", done, 1);
    @(posedge clk); #1;
    check("zero_len_cycle3_ready", cmd_ready, 1);
    check("zero_len_requests", rd_cnt + wr_cnt, 0);
    check("zero_len_done_pulses", done_cnt, 1);
    start_cmd(8'hA8, 8'hB8, 9'd2);
    wait_done();
    check("after_zero_wr_count", wr_cnt, 2);
    check_copy(8'hB8, 16'h0C00, 2);

    // Reset in the middle of a long copy, then a fresh copy.
    preload(8'h00, 16'h2000, 64);
    start_cmd(8'h00, 8'h60, 9'd64);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("midreset_outputs", {cmd_ready, done, sp_rd_en, sp_wr_en, sp_addr, sp_d, sp_stall}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midreset_idle", cmd_ready, 1);
    preload(8'hD0, 16'h0D00, 4);
    start_cmd(8'hD0, 8'hE0, 9'd4);
    wait_done();
    check("post_reset_rd_count", rd_cnt, 4);
    check("post_reset_wr_count", wr_cnt, 4);
    check("post_reset_done_pulses", done_cnt, 1);
    check("post_reset_protocol", proto_viol(), 0);
    check_copy(8'hE0, 16'h0D00, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
